// File: rtl/hsem_task_queue.sv
// hsem_task_queue
// Per-core task mailbox. Bus writes qualified by wr_en & task_en push a task
// word into the FIFO selected by ch_sel. The core that owns a channel reads its
// head on tsk_stat and pops it with pop_en once the task has been consumed.
//
// Ports
//   hclk, hresetn  clock and asynchronous active-low reset
//   wr_en, task_en write strobe and task-queue decode; a push is wr_en & task_en
//   ihwdata        bus write data; the low TASK_WIDTH bits are stored
//   pop_en         pop strobe for channel ch_sel
//   ch_sel         target channel for push and pop
//   irq_en         per-channel interrupt enable
//   ovf_clr        per-channel overflow-flag clear
//   tsk_stat       head entry per channel (0 when empty)
//   tsk_cnt        occupancy per channel
//   tsk_valid      channel non-empty
//   tsk_full       channel holds DEPTH entries
//   tsk_ovf        sticky overflow flag (push dropped on a full channel)
//   tsk_irq        tsk_valid & irq_en
module hsem_task_queue #(
  parameter int AHB_DATA_WIDTH = 32,
  parameter int TASK_WIDTH     = 32,
  parameter int NUM_CH         = 4,
  parameter int DEPTH          = 4,
  localparam int CH_W          = $clog2(NUM_CH),
  localparam int CNT_W         = $clog2(DEPTH) + 1
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic                         wr_en,
  input  logic [AHB_DATA_WIDTH-1:0]    ihwdata,
  input  logic                         task_en,
  input  logic                         pop_en,
  input  logic [CH_W-1:0]              ch_sel,
  input  logic [NUM_CH-1:0]            irq_en,
  input  logic [NUM_CH-1:0]            ovf_clr,
  output logic [NUM_CH*TASK_WIDTH-1:0] tsk_stat,
  output logic [NUM_CH*CNT_W-1:0]      tsk_cnt,
  output logic [NUM_CH-1:0]            tsk_valid,
  output logic [NUM_CH-1:0]            tsk_full,
  output logic [NUM_CH-1:0]            tsk_ovf,
  output logic [NUM_CH-1:0]            tsk_irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic push_req_s;
  logic [TASK_WIDTH-1:0] task_word_s;

  assign push_req_s  = wr_en & task_en;
  assign task_word_s = ihwdata[TASK_WIDTH-1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [TASK_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  ovf_r;
    logic                  sel_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  do_pop_s;
    logic                  do_push_s;
    logic                  drop_s;

    // An out-of-range ch_sel never matches any channel index, so it is ignored.
    assign sel_s     = (int'(ch_sel) == i);
    assign empty_s   = (cnt_r == CNT_ZERO);
    assign full_s    = (cnt_r == CNT_DEPTH);
    assign do_pop_s  = pop_en & sel_s & ~empty_s;
    // A pop in the same cycle frees the slot a push on a full channel needs.
    assign do_push_s = push_req_s & sel_s & (~full_s | do_pop_s);
    assign drop_s    = push_req_s & sel_s & full_s & ~do_pop_s;

    // Task storage; deliberately not reset, empty channels mask it on tsk_stat.
    always_ff @(posedge hclk) begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= task_word_s;
      end
    end

    // Pointers, occupancy and sticky overflow flag for this channel.
    always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        cnt_r    <= CNT_ZERO;
        ovf_r    <= 1'b0;
      end else begin
        if (do_push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (do_pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        if (do_push_s && !do_pop_s) begin
          cnt_r <= cnt_r + CNT_ONE;
        end else if (do_pop_s && !do_push_s) begin
          cnt_r <= cnt_r - CNT_ONE;
        end
        // Set beats clear when both happen in one cycle.
        if (drop_s) begin
          ovf_r <= 1'b1;
        end else if (ovf_clr[i]) begin
          ovf_r <= 1'b0;
        end
      end
    end

    assign tsk_stat[i*TASK_WIDTH +: TASK_WIDTH] = empty_s ? {TASK_WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign tsk_cnt[i*CNT_W +: CNT_W]            = cnt_r;
    assign tsk_valid[i]                         = ~empty_s;
    assign tsk_full[i]                          = full_s;
    assign tsk_ovf[i]                           = ovf_r;
    assign tsk_irq[i]                           = ~empty_s & irq_en[i];
  end

endmodule
